timer_master: RTL and testbench

Bus initiator for the memory-mapped 32-bit timer peripheral. It converts single-word commands (CLEAR, START, STOP, READ, READ_SNAP) from a controller into the timer's byte-wide chip-select/read-write bus cycles. It writes the control register at offset 4 and assembles the four count bytes at offsets 0–3 into one 32-bit result. It sits between the controller logic and the timer's `addr`/`idata`/`odata`/`cs_`/`rw_` pins. It is the only writer of the timer control register.

---
 rtl/timer_master.sv | 138 +++++++++++++
 tb/tb_timer_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_master.sv
// timer_master: turns single-word controller commands into byte-wide timer bus cycles
// and assembles the four count bytes into one 32-bit response.
module timer_master #(
    parameter int TIMER_BASE     = 0,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic [2:0]                cmd,
    output logic                      cmd_ready,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_data,
    output logic                      err,
    output logic                      running,
    output logic [MEM_ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH-1:0]     rdata,
    output logic                      cs_,
    output logic                      rw_
);
    localparam logic BUS_WRITE = 1'b0;
    localparam logic BUS_READ  = 1'b1;
    localparam logic [MEM_ADDR_WIDTH-1:0] A_BASE = MEM_ADDR_WIDTH'(TIMER_BASE);
    localparam logic [MEM_ADDR_WIDTH-1:0] A_CTRL = MEM_ADDR_WIDTH'(TIMER_BASE + 4);
    localparam logic [DATA_WIDTH-1:0] C_START = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] C_STOP  = DATA_WIDTH'(4);

    typedef enum logic [2:0] {IDLE, WR, RD, SNAP_STOP, SNAP_START} state_t;

    state_t                    state, state_n;
    logic [1:0]                idx, idx_n;
    logic                      snap, snap_n;
    logic                      cs_n, rw_n, rsp_valid_n, err_n, running_n;
    logic [MEM_ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0]     wdata_n;
    logic [31:0]               rsp_data_n;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            snap      <= 1'b0;
            cs_       <= 1'b1;
            rw_       <= BUS_READ;
            addr      <= A_BASE;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            err       <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            snap      <= snap_n;
            cs_       <= cs_n;
            rw_       <= rw_n;
            addr      <= addr_n;
            wdata     <= wdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            err       <= err_n;
            running   <= running_n;
        end
    end

    // Next bus cycle is decided here and registered, so the pins never glitch.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        snap_n      = snap;
        cs_n        = 1'b1;
        rw_n        = BUS_READ;
        addr_n      = A_BASE;
        wdata_n     = '0;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        err_n       = 1'b0;
        running_n   = running;
        case (state)
            IDLE: if (cmd_valid) begin
                case (cmd)
                    3'd0, 3'd1, 3'd2: begin
                        state_n = WR;
                        cs_n    = 1'b0;
                        rw_n    = BUS_WRITE;
                        addr_n  = A_CTRL;
                        wdata_n = DATA_WIDTH'(4'd1 << cmd[1:0]);
                    end
                    3'd3, 3'd4: begin
                        snap_n  = (cmd == 3'd4) && running;
                        state_n = snap_n ? SNAP_STOP : RD;
                        idx_n   = 2'd0;
                        cs_n    = 1'b0;
                        rw_n    = snap_n ? BUS_WRITE : BUS_READ;
                        addr_n  = snap_n ? A_CTRL : A_BASE;
                        wdata_n = snap_n ? C_STOP : '0;
                    end
                    default: err_n = 1'b1;
                endcase
            end
            WR: begin
                state_n   = IDLE;
                running_n = (wdata == C_START) ? 1'b1 : (wdata == C_STOP) ? 1'b0 : running;
            end
            SNAP_STOP: begin
                state_n = RD;
                idx_n   = 2'd0;
                cs_n    = 1'b0;
                addr_n  = A_BASE;
            end
            RD: begin
                rsp_data_n[{idx, 3'b000} +: 8] = rdata[7:0];
                if (idx == 2'd3) begin
                    state_n     = snap ? SNAP_START : IDLE;
                    rsp_valid_n = !snap;
                    cs_n        = !snap;
                    rw_n        = snap ? BUS_WRITE : BUS_READ;
                    addr_n      = snap ? A_CTRL : A_BASE;
                    wdata_n     = snap ? C_START : '0;
                end else begin
                    idx_n  = idx + 2'd1;
                    cs_n   = 1'b0;
                    addr_n = A_BASE + MEM_ADDR_WIDTH'(idx_n);
                end
            end
            SNAP_START: begin
                state_n     = IDLE;
                snap_n      = 1'b0;
                rsp_valid_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_timer_master.sv
// tb_timer_master: drives timer_master against a behavioural timer peripheral and
// scores responses through a queue popped by an independent monitor.
module tb_timer_master;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 0, rst = 1, cmd_valid = 0;
    logic [2:0]    cmd = 0;
    logic          cmd_ready, rsp_valid, err, running, cs_, rw_;
    logic [31:0]   rsp_data;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;

    timer_master #(.TIMER_BASE(0), .MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err), .running(running),
        .addr(addr), .wdata(wdata), .rdata(rdata), .cs_(cs_), .rw_(rw_)
    );

    always #5 clk = ~clk;

    // Behavioural timer: writes and increments both act on the pre-edge enable.
    logic [31:0] tm_count = 0, ref_count = 0;
    logic        tm_en = 0, load = 0;
    int          cyc = 0;
    wire         tm_wr = !cs_ && !rw_ && (addr == 8'd4);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ref_count <= load ? 32'h12FFFFFE : ref_count + 1;
        if (load) tm_count <= 32'h12FFFFFE;
        else if (tm_wr && wdata[0]) tm_count <= 0;
        else if (tm_en) tm_count <= tm_count + 1;
        if (tm_wr && wdata[1]) tm_en <= 1'b1;
        if (tm_wr && wdata[2]) tm_en <= 1'b0;
    end
    assign rdata = (addr < 8'd4) ? tm_count[addr[1:0]*8 +: 8] : {7'b0, tm_en};

    typedef struct { logic is_err; logic [31:0] data; } exp_t;
    exp_t sb[$];
    int   n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_err, input logic [31:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rsp_valid || err) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: rsp_valid=%b err=%b data=%h, none expected", rsp_valid, err, rsp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_err !== err || e.is_err === rsp_valid || (!e.is_err && rsp_data !== e.data)) begin
                    n_fail++;
                    $display("FAIL response: got err=%b rsp=%b data=%h expected err=%b data=%h",
                             err, rsp_valid, rsp_data, e.is_err, e.data);
                end
            end
        end
    end

    // Accepts at the next edge; returns #1 into cycle 1.
    task automatic send(input logic [2:0] c, input logic ld);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1;
        cmd = c;
        load = ld;
        @(posedge clk);
        #1;
        cmd_valid = 0;
        load = 0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    int t_start, t_stop;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_cs", 32'(cs_), 32'd1);
        chk("rst_rw", 32'(rw_), 32'd1);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_outs", {rsp_valid, err, running, cmd_ready}, 32'b0001);
        chk("rst_rsp_data", rsp_data, 32'd0);

        // CLEAR write cycle, then a READ sees zero
        send(3'd0, 0);
        chk("clr_bus", {cs_, rw_, addr, wdata}, {1'b0, 1'b0, 8'd4, 8'd1});
        chk("clr_ready_c1", 32'(cmd_ready), 32'd0);
        step();
        chk("clr_ready_c2", {cmd_ready, cs_}, 32'b11);
        chk("clr_count", tm_count, 32'd0);
        push(0, 32'd0);
        send(3'd3, 0);
        drain();

        // START, ~300 cycles, STOP, READ
        send(3'd0, 0);
        send(3'd1, 0);
        t_start = cyc;
        step();
        chk("start_running", 32'(running), 32'd1);
        repeat (300) @(posedge clk);
        send(3'd2, 0);
        t_stop = cyc;
        step();
        chk("stop_running", 32'(running), 32'd0);
        push(0, 32'(t_stop - t_start));
        send(3'd3, 0);
        for (int k = 0; k < 4; k++) begin
            chk("read_bus", {cs_, rw_, addr}, {1'b0, 1'b1, 8'(k)});
            step();
        end
        chk("read_c5", {rsp_valid, cmd_ready}, 32'b11);
        drain();

        // READ_SNAP while running with a preloaded count
        send(3'd1, 0);
        repeat (3) step();
        push(0, 32'h12FFFFFF);
        send(3'd4, 1);
        chk("snap_stop", {cs_, rw_, addr, wdata}, {1'b0, 1'b0, 8'd4, 8'd4});
        step();
        for (int k = 0; k < 4; k++) begin
            chk("snap_read", {cs_, rw_, addr, running}, {1'b0, 1'b1, 8'(k), 1'b1});
            step();
        end
        chk("snap_start", {cs_, rw_, addr, wdata}, {1'b0, 1'b0, 8'd4, 8'd2});
        step();
        chk("snap_c7", {rsp_valid, running, cmd_ready}, 32'b111);
        chk("snap_lost", ref_count - tm_count, 32'd5);
        drain();

        // READ_SNAP while stopped behaves like READ
        send(3'd2, 0);
        step();
        push(0, tm_count);
        send(3'd4, 0);
        for (int k = 0; k < 4; k++) begin
            chk("snap_idle_bus", {cs_, rw_, addr}, {1'b0, 1'b1, 8'(k)});
            step();
        end
        chk("snap_idle_c5", {rsp_valid, cmd_ready, cs_}, 32'b111);
        drain();

        // Illegal command followed by back-to-back READ
        push(1, 32'd0);
        send(3'd6, 0);
        chk("illegal_c1", {cs_, cmd_ready, err}, 32'b111);
        push(0, tm_count);
        send(3'd3, 0);
        chk("b2b_read", {cs_, addr}, {1'b0, 8'd0});
        drain();

        // Reset during cycle 3 of READ_SNAP
        send(3'd1, 0);
        repeat (3) step();
        send(3'd4, 0);
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        chk("abort_state", {cs_, running, rsp_valid, cmd_ready}, 32'b1001);
        chk("abort_timer", 32'(tm_en), 32'd0);
        repeat (10) step();
        chk("abort_still_stopped", 32'(tm_en), 32'd0);
        send(3'd1, 0);
        step();
        chk("restart", {running, tm_en}, 32'b11);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
